// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit.
// A 12-state sequencer drives the datapath controls from the current state,
// mem_ready and, where the instruction matters, the opcode. Memory states
// (FETCH, MEMRD, MEMWR) are guarded by a wait counter that abandons an access
// after MEM_WAIT_MAX idle cycles and reports it with a one-cycle mem_err.
//
//   state  | meaning
//   FETCH  | read instruction at PC, PC <= PC+4 when memory answers
//   DECODE | read registers, precompute branch target, dispatch on opcode
//   MEMADR | compute load/store effective address
//   MEMRD  | load data read, waits for mem_ready
//   MEMWB  | write loaded data to rt
//   MEMWR  | store data write, waits for mem_ready
//   RTEXEC | R-type ALU operation
//   RTWB   | write ALU result to rd
//   BEQ    | compare and conditionally load branch target
//   IEXEC  | immediate ALU operation (addi/andi/ori)
//   IWB    | write immediate result to rt
//   JUMP   | load jump target into PC
module multicycle_control #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUsrcA,
  output logic       ZeroExt,
  output logic [1:0] PCSource,
  output logic [1:0] ALUsrcB,
  output logic [1:0] ALUop,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQ    = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [7:0] WAIT_MAX_C = MEM_WAIT_MAX[7:0];

  state_t     state_q, state_d;
  state_t     cur_state;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       in_wait;
  logic       timeout;
  logic       op_legal;
  logic       op_logic_imm;
  logic       rdy_eff;

  // While reset is held the outputs look like an idle FETCH, so the
  // datapath never sees a stale access from the state being abandoned.
  assign cur_state = rst ? S_FETCH : state_q;
  assign rdy_eff   = mem_ready & ~rst;
  assign state     = cur_state;

  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // Completion wins over timeout when both land on the same cycle.
  assign timeout = in_wait && !mem_ready && (wait_cnt_q == WAIT_MAX_C);

  assign op_logic_imm = (opcode == OP_ANDI) || (opcode == OP_ORI);

  // Opcode legality for the DECODE dispatch.
  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW: op_legal = 1'b1;
      default:                                                       op_legal = 1'b0;
    endcase
  end

  // Wait counter: counts idle memory cycles, any exit or handshake clears it.
  // Non-memory states always leave it at zero, which covers the clear on entry.
  always_comb begin
    if (in_wait && !mem_ready && !timeout) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = 8'd0;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:              state_d = S_MEMADR;
          OP_RTYPE:                  state_d = S_RTEXEC;
          OP_BEQ:                    state_d = S_BEQ;
          OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IEXEC;
          OP_J:                      state_d = S_JUMP;
          default:                   state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW) begin
          state_d = S_MEMRD;
        end else if (opcode == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMRD: begin
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timeout) begin
          state_d = S_FETCH;
        end
      end
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR: begin
        if (mem_ready || timeout) begin
          state_d = S_FETCH;
        end
      end
      S_RTEXEC: state_d = S_RTWB;
      S_RTWB:   state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Control decode; anything not driven by a state stays 0.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUsrcA     = 1'b0;
    ZeroExt     = 1'b0;
    PCSource    = 2'b00;
    ALUsrcB     = 2'b00;
    ALUop       = 2'b00;
    illegal_op  = 1'b0;
    case (cur_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUsrcB = 2'b01;
        IRWrite = rdy_eff;
        PCWrite = rdy_eff;
      end
      S_DECODE: begin
        ALUsrcB    = 2'b11;
        illegal_op = ~op_legal;
      end
      S_MEMADR: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_RTEXEC: begin
        ALUsrcA = 1'b1;
        ALUop   = 2'b10;
      end
      S_RTWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BEQ: begin
        ALUsrcA     = 1'b1;
        ALUop       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_IEXEC: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'b10;
        if (op_logic_imm) begin
          ALUop   = 2'b11;
          ZeroExt = 1'b1;
        end
      end
      S_IWB: begin
        RegWrite = 1'b1;
        ZeroExt  = op_logic_imm;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: begin
      end
    endcase
  end

  // Timeout pulse is suppressed while reset is held.
  assign mem_err = timeout & ~rst;

  // State and wait-counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, reset corner cases and
// randomized instruction streams checked against an instruction-level trace model.
module tb_multicycle_control;

  localparam int MAXW = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, RegWrite, RegDst, ALUsrcA, ZeroExt;
  logic [1:0] PCSource, ALUsrcB, ALUop;
  logic       illegal_op, mem_err;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUsrcA(ALUsrcA), .ZeroExt(ZeroExt), .PCSource(PCSource),
    .ALUsrcB(ALUsrcB), .ALUop(ALUop), .illegal_op(illegal_op),
    .mem_err(mem_err), .state(state)
  );

  // Control word layout used by the model.
  localparam logic [18:0] C_PCW  = 19'd1 << 18;
  localparam logic [18:0] C_PCWC = 19'd1 << 17;
  localparam logic [18:0] C_IORD = 19'd1 << 16;
  localparam logic [18:0] C_MRD  = 19'd1 << 15;
  localparam logic [18:0] C_MWR  = 19'd1 << 14;
  localparam logic [18:0] C_M2R  = 19'd1 << 13;
  localparam logic [18:0] C_IRW  = 19'd1 << 12;
  localparam logic [18:0] C_RW   = 19'd1 << 11;
  localparam logic [18:0] C_RDST = 19'd1 << 10;
  localparam logic [18:0] C_ASA  = 19'd1 << 9;
  localparam logic [18:0] C_ZX   = 19'd1 << 8;
  localparam logic [18:0] C_PCS1 = 19'd1 << 6;
  localparam logic [18:0] C_PCS2 = 19'd2 << 6;
  localparam logic [18:0] C_ASB1 = 19'd1 << 4;
  localparam logic [18:0] C_ASB2 = 19'd2 << 4;
  localparam logic [18:0] C_ASB3 = 19'd3 << 4;
  localparam logic [18:0] C_AOP1 = 19'd1 << 2;
  localparam logic [18:0] C_AOP2 = 19'd2 << 2;
  localparam logic [18:0] C_AOP3 = 19'd3 << 2;
  localparam logic [18:0] C_ILL  = 19'd1 << 1;
  localparam logic [18:0] C_MERR = 19'd1;

  logic [18:0] dut_ctl;
  assign dut_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                    RegWrite, RegDst, ALUsrcA, ZeroExt, PCSource, ALUsrcB, ALUop,
                    illegal_op, mem_err};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level trace model ----------------
  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [18:0] ctl;
  } cyc_t;

  cyc_t exp_q[$];

  function automatic void push(logic [5:0] op, logic rdy, logic [3:0] st, logic [18:0] ctl);
    cyc_t c;
    c.op = op; c.rdy = rdy; c.st = st; c.ctl = ctl;
    exp_q.push_back(c);
  endfunction

  function automatic logic noise();
    return 1'($urandom_range(0, 1));
  endfunction

  // A memory access that sees w idle cycles before the handshake; more than
  // MAXW idle cycles means the access is abandoned on the (MAXW+1)th cycle.
  function automatic bit mem_phase(logic [5:0] op, logic [3:0] st, logic [18:0] base,
                                   logic [18:0] on_ready, int w);
    if (w > MAXW) begin
      for (int i = 0; i < MAXW; i++) push(op, 1'b0, st, base);
      push(op, 1'b0, st, base | C_MERR);
      return 1'b0;
    end
    for (int i = 0; i < w; i++) push(op, 1'b0, st, base);
    push(op, 1'b1, st, base | on_ready);
    return 1'b1;
  endfunction

  function automatic void gen_instr(logic [5:0] op, int fw, int mw);
    if (!mem_phase(op, 4'd0, C_MRD | C_ASB1, C_IRW | C_PCW, fw)) return;
    case (op)
      6'b100011: begin
        push(op, noise(), 4'd1, C_ASB3);
        push(op, noise(), 4'd2, C_ASA | C_ASB2);
        if (mem_phase(op, 4'd3, C_IORD | C_MRD, 19'd0, mw))
          push(op, noise(), 4'd4, C_M2R | C_RW);
      end
      6'b101011: begin
        push(op, noise(), 4'd1, C_ASB3);
        push(op, noise(), 4'd2, C_ASA | C_ASB2);
        void'(mem_phase(op, 4'd5, C_IORD | C_MWR, 19'd0, mw));
      end
      6'b000000: begin
        push(op, noise(), 4'd1, C_ASB3);
        push(op, noise(), 4'd6, C_ASA | C_AOP2);
        push(op, noise(), 4'd7, C_RDST | C_RW);
      end
      6'b000100: begin
        push(op, noise(), 4'd1, C_ASB3);
        push(op, noise(), 4'd8, C_ASA | C_AOP1 | C_PCWC | C_PCS1);
      end
      6'b001000: begin
        push(op, noise(), 4'd1, C_ASB3);
        push(op, noise(), 4'd9, C_ASA | C_ASB2);
        push(op, noise(), 4'd10, C_RW);
      end
      6'b001100, 6'b001101: begin
        push(op, noise(), 4'd1, C_ASB3);
        push(op, noise(), 4'd9, C_ASA | C_ASB2 | C_AOP3 | C_ZX);
        push(op, noise(), 4'd10, C_RW | C_ZX);
      end
      6'b000010: begin
        push(op, noise(), 4'd1, C_ASB3);
        push(op, noise(), 4'd11, C_PCW | C_PCS2);
      end
      default: push(op, noise(), 4'd1, C_ASB3 | C_ILL);
    endcase
  endfunction

  task automatic drain(input string tag);
    cyc_t c;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      @(negedge clk);
      opcode    = c.op;
      mem_ready = c.rdy;
      #1;
      chk({tag, "_state"}, 32'(state), 32'(c.st));
      chk({tag, "_ctl"}, 32'(dut_ctl), 32'(c.ctl));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [5:0]  op;
    int          len;
    logic [11:0] rdy;
    logic [47:0] seq;
    logic [11:0] err;
    logic [11:0] ill;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(logic [5:0] op, int len, logic [11:0] rdy, logic [47:0] seq,
                              logic [11:0] err, logic [11:0] ill);
    vec_t v;
    v.op = op; v.len = len; v.rdy = rdy; v.seq = seq; v.err = err; v.ill = ill;
    return v;
  endfunction

  logic [5:0] rnd_ops[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] st_exp;
    logic [5:0] op;
    int         r;

    // state sequence nibble i = expected state in cycle i
    tbl[0]  = mk(6'b100011, 9, 12'h19C, 48'h433321000, 12'h000, 12'h000); // lw, waits
    tbl[1]  = mk(6'b000000, 4, 12'h005, 48'h7610,      12'h000, 12'h000); // R-type
    tbl[2]  = mk(6'b001101, 4, 12'h00F, 48'hA910,      12'h000, 12'h000); // ori
    tbl[3]  = mk(6'b000100, 3, 12'h007, 48'h810,       12'h000, 12'h000); // beq
    tbl[4]  = mk(6'b000010, 3, 12'h001, 48'hB10,       12'h000, 12'h000); // j
    tbl[5]  = mk(6'b101011, 4, 12'h009, 48'h5210,      12'h000, 12'h000); // sw
    tbl[6]  = mk(6'b111111, 2, 12'h003, 48'h10,        12'h000, 12'h002); // illegal
    tbl[7]  = mk(6'b101011, 7, 12'h003, 48'h5555210,   12'h040, 12'h000); // sw timeout
    tbl[8]  = mk(6'b101011, 7, 12'h041, 48'h5555210,   12'h000, 12'h000); // sw ready at limit
    tbl[9]  = mk(6'b100011, 4, 12'h000, 48'h0000,      12'h008, 12'h000); // fetch timeout
    tbl[10] = mk(6'b001100, 4, 12'h001, 48'hA910,      12'h000, 12'h000); // andi
    tbl[11] = mk(6'b001000, 4, 12'h001, 48'hA910,      12'h000, 12'h000); // addi
    tbl[12] = mk(6'b100011, 7, 12'h001, 48'h3333210,   12'h040, 12'h000); // lw read timeout
    tbl[13] = mk(6'b010101, 3, 12'h006, 48'h100,       12'h000, 12'h004); // illegal after wait

    rnd_ops[0] = 6'b100011; rnd_ops[1] = 6'b101011; rnd_ops[2] = 6'b000000;
    rnd_ops[3] = 6'b000100; rnd_ops[4] = 6'b001000; rnd_ops[5] = 6'b001100;
    rnd_ops[6] = 6'b001101; rnd_ops[7] = 6'b000010; rnd_ops[8] = 6'b111111;

    // Reset: outputs look like an idle FETCH even with mem_ready high.
    rst = 1'b1; opcode = 6'b000000; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctl", 32'(dut_ctl), 32'(C_MRD | C_ASB1));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vectors.
    for (int t = 0; t < 14; t++) begin
      for (int i = 0; i < tbl[t].len; i++) begin
        @(negedge clk);
        opcode    = tbl[t].op;
        mem_ready = tbl[t].rdy[i];
        #1;
        st_exp = tbl[t].seq[4*i +: 4];
        chk($sformatf("vec%0d_c%0d_state", t, i), 32'(state), 32'(st_exp));
        chk($sformatf("vec%0d_c%0d_mem_err", t, i), 32'(mem_err), 32'(tbl[t].err[i]));
        chk($sformatf("vec%0d_c%0d_illegal", t, i), 32'(illegal_op), 32'(tbl[t].ill[i]));
        chk($sformatf("vec%0d_c%0d_regwrite", t, i), 32'(RegWrite),
            32'((st_exp == 4'd4) || (st_exp == 4'd7) || (st_exp == 4'd10)));
      end
    end

    // Reset in the middle of a stalled store.
    push(6'b101011, 1'b1, 4'd0, C_MRD | C_ASB1 | C_IRW | C_PCW);
    push(6'b101011, 1'b0, 4'd1, C_ASB3);
    push(6'b101011, 1'b1, 4'd2, C_ASA | C_ASB2);
    push(6'b101011, 1'b0, 4'd5, C_IORD | C_MWR);
    push(6'b101011, 1'b0, 4'd5, C_IORD | C_MWR);
    drain("pre_rst");
    @(negedge clk);
    mem_ready = 1'b0;
    rst       = 1'b1;
    #1;
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_memwrite", 32'(MemWrite), 32'd0);
    chk("midrst_ctl", 32'(dut_ctl), 32'(C_MRD | C_ASB1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Three idle fetch cycles must still complete: the counter was cleared.
    gen_instr(6'b100011, MAXW, 0);
    drain("post_rst");

    // Randomized instruction stream against the trace model.
    for (int n = 0; n < 120; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 9) op = 6'($urandom);
      else        op = rnd_ops[r];
      gen_instr(op, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      drain("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
